hd44780_if: RTL and testbench

HD44780_IF -- requirements
Module: hd44780_if

---
 rtl/hd44780_pkg.sv | 27 ++
 rtl/hd44780_strobe.sv | 40 ++++
 rtl/hd44780_if.sv | 158 +++++++++++++++
 tb/tb_hd44780_if.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/hd44780_pkg.sv
// Shared definitions for the HD44780 write-only interface.
//   state_t    : FSM states (power-up, init stepping, idle, strobe phases, wait)
//   CMD_*      : HD44780 command bytes used by the init sequence and wait rule
//   cyc/max1   : microsecond -> clock-cycle conversion helpers
package hd44780_pkg;

  typedef enum logic [2:0] {PWR, INIT, IDLE, SETUP, EHI, ELO, WAIT} state_t;

  localparam logic [7:0] CMD_CLEAR   = 8'h01;
  localparam logic [7:0] CMD_HOME    = 8'h02;
  localparam logic [7:0] CMD_ENTRY   = 8'h06;
  localparam logic [7:0] CMD_DISP_ON = 8'h0C;
  localparam logic [7:0] CMD_FUNC8   = 8'h38;
  localparam logic [7:0] CMD_FUNC4   = 8'h28;

  function automatic int max1(input int x);
    return (x < 1) ? 1 : x;
  endfunction

  // Cycles for a delay in microseconds, never less than one.
  function automatic int cyc(input int hz, input int us);
    longint v;
    v = longint'(hz / 1_000_000) * longint'(us);
    return (v < 1) ? 1 : int'(v);
  endfunction

endpackage

// File: rtl/hd44780_strobe.sv
// Phase timer for one bus write (SETUP / EHI / ELO).
//   CLK, resetn : clock, async active-low reset
//   phase       : current FSM state of the parent
//   tick        : high in the last cycle of the current strobe phase
// The counter restarts on every phase change, so the parent only has to
// advance its state when tick is seen.
module hd44780_strobe
  import hd44780_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic       CLK,
  input  logic       resetn,
  input  logic [2:0] phase,
  output logic       tick
);

  localparam int T_SU = max1(CLK_HZ / 25_000_000);  // >= 40 ns
  localparam int T_EN = max1(CLK_HZ / 4_000_000);   // >= 250 ns
  localparam logic [15:0] SU_LAST = 16'(T_SU - 1);
  localparam logic [15:0] EN_LAST = 16'(T_EN - 1);

  logic [15:0] cnt;
  logic        active;

  assign active = (phase == SETUP) || (phase == EHI) || (phase == ELO);

  always_comb begin
    tick = 1'b0;
    if (phase == SETUP || phase == ELO) tick = (cnt == SU_LAST);
    else if (phase == EHI)              tick = (cnt == EN_LAST);
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn)               cnt <= '0;
    else if (!active || tick)  cnt <= '0;
    else                       cnt <= cnt + 16'd1;
  end

endmodule

// File: rtl/hd44780_if.sv
// Write-only HD44780 character LCD controller.
//   CLK, resetn           : clock, async active-low reset
//   req_valid/req_ready   : write handshake, accepted when both high
//   req_rs, req_byte      : 0 = command, 1 = data; byte to write
//   init_done             : power-up init sequence complete
//   busy                  : FSM not in IDLE
//   lcd_rs/rw/e/d         : LCD pins (rw tied low; 4-bit mode uses lcd_d[7:4])
// After reset the block waits out the LCD power-up time, replays the init
// ROM, then serves requests. Each write is SETUP -> EHI -> ELO (twice in
// 4-bit mode, high nibble first) followed by a command-dependent WAIT.
module hd44780_if
  import hd44780_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BUS4       = 0,
  parameter int T_PWR_US   = 40000,
  parameter int T_SHORT_US = 40,
  parameter int T_LONG_US  = 2000
) (
  input  logic       CLK,
  input  logic       resetn,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rs,
  input  logic [7:0] req_byte,
  output logic       init_done,
  output logic       busy,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_d
);

  localparam logic [31:0] PWR_LAST   = 32'(cyc(CLK_HZ, T_PWR_US) - 1);
  localparam logic [31:0] SHORT_LAST = 32'(cyc(CLK_HZ, T_SHORT_US) - 1);
  localparam logic [31:0] LONG_LAST  = 32'(cyc(CLK_HZ, T_LONG_US) - 1);
  localparam int          N_STEPS    = (BUS4 != 0) ? 8 : 4;

  // ROM entry = {single_nibble, byte}. Single-nibble entries only put the
  // upper nibble on the bus and always take the long wait; they are the
  // 8-bit -> 4-bit mode switch handshake.
  localparam logic [7:0][8:0] ROM4 = {
    {1'b0, CMD_ENTRY}, {1'b0, CMD_CLEAR}, {1'b0, CMD_DISP_ON}, {1'b0, CMD_FUNC4},
    {1'b1, 8'h20},     {1'b1, 8'h30},     {1'b1, 8'h30},       {1'b1, 8'h30}
  };
  localparam logic [3:0][8:0] ROM8 = {
    {1'b0, CMD_ENTRY}, {1'b0, CMD_CLEAR}, {1'b0, CMD_DISP_ON}, {1'b0, CMD_FUNC8}
  };

  state_t      state;
  logic [31:0] cnt;
  logic [2:0]  step;
  logic [3:0]  lo_q;     // low nibble of the byte in flight (4-bit mode)
  logic        last_q;   // the strobe in progress is the final one
  logic        long_q;   // this write needs the long post-write wait
  logic        tick;

  logic [8:0]  rom_ent;
  logic        start, ld_rs, ld_single;
  logic [7:0]  ld_byte;
  logic [31:0] wait_last;

  hd44780_strobe #(.CLK_HZ(CLK_HZ)) u_strobe (
    .CLK    (CLK),
    .resetn (resetn),
    .phase  (state),
    .tick   (tick)
  );

  assign lcd_rw    = 1'b0;
  assign req_ready = (state == IDLE) && init_done;
  assign busy      = (state != IDLE);
  assign wait_last = long_q ? LONG_LAST : SHORT_LAST;

  // Write source: init ROM while stepping INIT, otherwise the request port.
  always_comb begin
    rom_ent   = (BUS4 != 0) ? ROM4[step] : ROM8[step[1:0]];
    ld_single = (state == INIT) && rom_ent[8];
    ld_rs     = (state == INIT) ? 1'b0 : req_rs;
    ld_byte   = (state == INIT) ? rom_ent[7:0] : req_byte;
    start     = (state == INIT) || (state == IDLE && req_valid && init_done);
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state     <= PWR;
      cnt       <= '0;
      step      <= '0;
      init_done <= 1'b0;
      lcd_e     <= 1'b0;
      lcd_rs    <= 1'b0;
      lcd_d     <= '0;
      lo_q      <= '0;
      last_q    <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      case (state)
        PWR: begin
          if (cnt == PWR_LAST) begin
            cnt   <= '0;
            state <= INIT;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        INIT, IDLE: begin
          if (start) begin
            state  <= SETUP;
            lcd_rs <= ld_rs;
            lcd_d  <= (BUS4 != 0) ? {ld_byte[7:4], 4'h0} : ld_byte;
            lo_q   <= ld_byte[3:0];
            last_q <= (BUS4 == 0) || ld_single;
            long_q <= ld_single ||
                      (!ld_rs && (ld_byte == CMD_CLEAR || ld_byte == CMD_HOME ||
                                  ld_byte == 8'h03));
          end
        end
        SETUP: if (tick) begin
          state <= EHI;
          lcd_e <= 1'b1;
        end
        EHI: if (tick) begin
          state <= ELO;
          lcd_e <= 1'b0;
        end
        ELO: if (tick) begin
          if (last_q) begin
            state <= WAIT;
            cnt   <= '0;
          end else begin
            // ELO of the high nibble doubles as the inter-nibble gap
            state  <= SETUP;
            lcd_d  <= {lo_q, 4'h0};
            last_q <= 1'b1;
          end
        end
        WAIT: begin
          if (cnt == wait_last) begin
            cnt <= '0;
            if (init_done) begin
              state <= IDLE;
            end else if (step == 3'(N_STEPS - 1)) begin
              state     <= IDLE;
              init_done <= 1'b1;
            end else begin
              step  <= step + 3'd1;
              state <= INIT;
            end
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        default: state <= PWR;
      endcase
    end
  end

endmodule

// File: tb/tb_hd44780_if.sv
// Scoreboard bench for hd44780_if at CLK_HZ = 1 MHz (T_SU = T_EN = 1 cycle,
// short wait 40, long wait 2000, power-up 40000). One 8-bit and one 4-bit
// instance run side by side. Stimulus pushes the expected {lcd_rs, lcd_d}
// of every strobe; per-instance monitors pop and compare on each lcd_e rise.
module tb_hd44780_if;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  logic       rst8 = 1'b1, v8 = 1'b0, rs8 = 1'b0;
  logic [7:0] b8 = '0;
  logic       rdy8, done8, busy8, lrs8, lrw8, le8;
  logic [7:0] ld8;

  logic       rst4 = 1'b1, v4 = 1'b0, rs4 = 1'b0;
  logic [7:0] b4 = '0;
  logic       rdy4, done4, busy4, lrs4, lrw4, le4;
  logic [7:0] ld4;

  logic [8:0] q8[$];
  logic [8:0] q4[$];
  int strobes8 = 0, strobes4 = 0;

  hd44780_if #(.CLK_HZ(1_000_000), .BUS4(0)) dut8 (
    .CLK(CLK), .resetn(rst8), .req_valid(v8), .req_ready(rdy8), .req_rs(rs8),
    .req_byte(b8), .init_done(done8), .busy(busy8), .lcd_rs(lrs8),
    .lcd_rw(lrw8), .lcd_e(le8), .lcd_d(ld8)
  );

  hd44780_if #(.CLK_HZ(1_000_000), .BUS4(1)) dut4 (
    .CLK(CLK), .resetn(rst4), .req_valid(v4), .req_ready(rdy4), .req_rs(rs4),
    .req_byte(b4), .init_done(done4), .busy(busy4), .lcd_rs(lrs4),
    .lcd_rw(lrw4), .lcd_e(le4), .lcd_d(ld4)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- monitors ----------------
  logic       pe8 = 1'b0, pe4 = 1'b0;
  int         hi8 = 0, hi4 = 0;
  logic [8:0] bus8 = '0, bus4 = '0;

  always @(negedge CLK) begin
    if (le8 && !pe8) begin
      strobes8++;
      bus8 = {lrs8, ld8};
      if (q8.size() == 0) begin
        checks++; errors++;
        $display("FAIL strobe8_unexpected: got %0h expected none", bus8);
      end else chk("strobe8_bus", bus8, q8.pop_front());
    end
    if (!le8 && pe8 && rst8) begin
      chk("strobe8_width", hi8, 1);
      chk("strobe8_stable", {lrs8, ld8}, bus8);
    end
    hi8 = le8 ? hi8 + 1 : 0;
    pe8 = le8;
  end

  always @(negedge CLK) begin
    if (le4 && !pe4) begin
      strobes4++;
      bus4 = {lrs4, ld4};
      if (q4.size() == 0) begin
        checks++; errors++;
        $display("FAIL strobe4_unexpected: got %0h expected none", bus4);
      end else chk("strobe4_bus", bus4, q4.pop_front());
    end
    if (!le4 && pe4 && rst4) begin
      chk("strobe4_width", hi4, 1);
      chk("strobe4_stable", {lrs4, ld4}, bus4);
    end
    hi4 = le4 ? hi4 + 1 : 0;
    pe4 = le4;
  end

  // ---------------- 8-bit instance ----------------
  // Issue one write; wn = negedges from the first lcd_e-low sample (ELO)
  // until req_ready, i.e. T_SU + wait length.
  task automatic send8(input logic rs, input logic [7:0] b, output int wn);
    int n;
    q8.push_back({rs, b});
    v8 = 1'b1; rs8 = rs; b8 = b;
    n = 0;
    while (!rdy8 && n < 5000) begin @(negedge CLK); n++; end
    chk("send8_ready", rdy8, 1);
    @(negedge CLK);
    v8 = 1'b0; rs8 = ~rs; b8 = ~b;   // must not disturb the write in flight
    n = 0;
    while (!le8 && n < 100) begin @(negedge CLK); n++; end
    n = 0;
    while (le8 && n < 100) begin @(negedge CLK); n++; end
    wn = 0;
    while (!rdy8 && wn < 5000) begin @(negedge CLK); wn++; end
  endtask

  task automatic run8();
    int n, wn, acc, last, s0;
    logic [7:0] arr[3];
    q8.push_back({1'b0, 8'h38}); q8.push_back({1'b0, 8'h0C});
    q8.push_back({1'b0, 8'h01}); q8.push_back({1'b0, 8'h06});
    rst8 = 1'b1;
    n = 0;
    while (!le8 && n < 45000) begin @(negedge CLK); n++; end
    chk("pwr8_first_e", n, 40002);          // PWR 40000 + INIT 1 + SETUP 1
    while (!done8 && n < 50000) begin @(negedge CLK); n++; end
    chk("init8_time", n, 42136);            // 3 x (1+3+40) + (1+3+2000)
    chk("init8_strobes", strobes8, 4);
    chk("init8_ready", rdy8, 1);

    send8(1'b1, 8'h41, wn); chk("wait_data41", wn, 41);
    send8(1'b0, 8'h01, wn); chk("wait_cmd01", wn, 2001);
    send8(1'b0, 8'h80, wn); chk("wait_cmd80", wn, 41);
    send8(1'b0, 8'h03, wn); chk("wait_cmd03", wn, 2001);
    send8(1'b0, 8'h04, wn); chk("wait_cmd04", wn, 41);
    send8(1'b1, 8'h01, wn); chk("wait_data01", wn, 41);

    // back-to-back with req_valid held high
    arr = '{8'h11, 8'h22, 8'h33};
    s0 = strobes8;
    foreach (arr[i]) q8.push_back({1'b1, arr[i]});
    v8 = 1'b1; rs8 = 1'b1; b8 = arr[0];
    acc = 0; n = 0; last = 0;
    while (acc < 3 && n < 1000) begin
      if (rdy8) begin
        if (acc > 0) chk("b2b_gap", n - last, 44);
        last = n; acc++;
        @(negedge CLK); n++;
        if (acc < 3) b8 = arr[acc]; else v8 = 1'b0;
      end else begin
        @(negedge CLK); n++;
      end
    end
    chk("b2b_accepts", acc, 3);
    n = 0;
    while (!rdy8 && n < 1000) begin @(negedge CLK); n++; end
    chk("b2b_strobes", strobes8 - s0, 3);

    // reset while lcd_e is high
    q8.push_back({1'b1, 8'h55});
    v8 = 1'b1; rs8 = 1'b1; b8 = 8'h55;
    n = 0;
    while (!le8 && n < 100) begin @(negedge CLK); n++; end
    v8 = 1'b0;
    chk("abort_saw_e", le8, 1);
    #2 rst8 = 1'b0;
    #1;
    chk("abort_e", le8, 0);
    chk("abort_init_done", done8, 0);
    chk("abort_ready", rdy8, 0);
    chk("abort_busy", busy8, 1);
    chk("abort_d", ld8, 0);
    repeat (2) @(negedge CLK);
    q8.push_back({1'b0, 8'h38});
    rst8 = 1'b1;
    n = 0;
    while (!le8 && n < 45000) begin @(negedge CLK); n++; end
    chk("restart_first_e", n, 40002);
    repeat (5) @(negedge CLK);
  endtask

  // ---------------- 4-bit instance ----------------
  task automatic run4();
    int n;
    logic [7:0] exp4[12];
    exp4 = '{8'h30, 8'h30, 8'h30, 8'h20, 8'h20, 8'h80,
             8'h00, 8'hC0, 8'h00, 8'h10, 8'h00, 8'h60};
    foreach (exp4[i]) q4.push_back({1'b0, exp4[i]});
    rst4 = 1'b1;
    n = 0;
    while (!done4 && n < 60000) begin @(negedge CLK); n++; end
    // 40000 + 4 x (1+3+2000) + 3 x (1+6+40) + (1+6+2000)
    chk("init4_time", n, 50164);
    chk("init4_strobes", strobes4, 12);

    q4.push_back({1'b1, 8'hA0}); q4.push_back({1'b1, 8'h50});
    v4 = 1'b1; rs4 = 1'b1; b4 = 8'hA5;
    n = 0;
    while (!rdy4 && n < 100) begin @(negedge CLK); n++; end
    chk("a5_ready", rdy4, 1);
    @(negedge CLK);
    v4 = 1'b0; b4 = 8'h00; rs4 = 1'b0;
    n = 1;
    while (!rdy4 && n < 1000) begin @(negedge CLK); n++; end
    chk("a5_cycle", n, 47);                 // 2 x (SETUP,EHI,ELO) + 40 + IDLE
    chk("a5_strobes", strobes4, 14);
  endtask

  initial begin
    #2 rst8 = 1'b0; rst4 = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_ready", rdy8, 0);
    chk("rst_busy", busy8, 1);
    chk("rst_init_done", done8, 0);
    chk("rst_e", le8, 0);
    chk("rst_d", ld8, 0);
    chk("rst_rs", lrs8, 0);
    chk("rst_rw", lrw8, 0);
    chk("rst4_busy", busy4, 1);
    chk("rst4_rw", lrw4, 0);
    chk("rst4_init_done", done4, 0);
    fork
      run8();
      run4();
    join
    chk("q8_empty", q8.size(), 0);
    chk("q4_empty", q4.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
